// File: rtl/tdm_pkg.sv
// Shared types and constants for the 4-channel TDM mux scanner.
package tdm_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StSample,
    StDone
  } state_e;

  // Select codes {s1,s0} per channel; the downstream mux is wired inverted.
  localparam logic [1:0] SelCh0 = 2'b11;
  localparam logic [1:0] SelCh1 = 2'b10;
  localparam logic [1:0] SelCh2 = 2'b01;
  localparam logic [1:0] SelCh3 = 2'b00;

  localparam logic [1:0] SelCode [4] = '{SelCh0, SelCh1, SelCh2, SelCh3};

endpackage

// File: rtl/settle_timer.sv
// Down-counter that paces how long the mux selects settle before a sample.
module settle_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         count,
  output logic         done
);

  logic [W-1:0] cnt_q;

  // Load takes priority; counting saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (count && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/tdm_mux4_scanner.sv
// Walks an external 4:1 mux across its channels and assembles one bit per
// channel into a frame, handed off with a valid/ready handshake.
module tdm_mux4_scanner
  import tdm_pkg::*;
#(
  parameter int unsigned SETTLE = 1,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cont,
  input  logic             y_in,
  output logic             s0,
  output logic             s1,
  output logic [3:0]       frame,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt
);

  // With no settle time each channel goes straight to its sample cycle.
  localparam state_e     EntrySt    = (SETTLE == 0) ? StSample : StSettle;
  localparam logic [3:0] SettleLoad = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

  state_e           state_q, state_d;
  logic [1:0]       ch_q, ch_d;
  logic [3:0]       frame_q, frame_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmr_load, tmr_count, tmr_done;

  settle_timer #(
    .W(4)
  ) u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (SettleLoad),
    .count    (tmr_count),
    .done     (tmr_done)
  );

  // State, channel, frame and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ch_q    <= 2'd0;
      frame_q <= 4'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: scan sequencing, sampling and frame handoff.
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    frame_d   = frame_q;
    cnt_d     = cnt_q;
    tmr_load  = 1'b0;
    tmr_count = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start || cont) begin
          ch_d     = 2'd0;
          frame_d  = 4'd0;
          state_d  = EntrySt;
          tmr_load = 1'b1;
        end
      end
      StSettle: begin
        if (tmr_done) begin
          state_d = StSample;
        end else begin
          tmr_count = 1'b1;
        end
      end
      StSample: begin
        frame_d[ch_q] = y_in;
        if (ch_q == 2'd3) begin
          state_d = StDone;
        end else begin
          ch_d     = ch_q + 2'd1;
          state_d  = EntrySt;
          tmr_load = 1'b1;
        end
      end
      StDone: begin
        if (frame_ready) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cont) begin
            ch_d     = 2'd0;
            frame_d  = 4'd0;
            state_d  = EntrySt;
            tmr_load = 1'b1;
          end else begin
            // Channel is kept so the selects stay put while idle.
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign {s1, s0}    = SelCode[ch_q];
  assign frame       = frame_q;
  assign frame_valid = (state_q == StDone);
  assign busy        = (state_q != StIdle);
  assign frame_cnt   = cnt_q;

endmodule

// File: tb/tb_tdm_mux4_scanner.sv
// Bench for tdm_mux4_scanner: one instance with SETTLE=1, one with SETTLE=0.
module tb_tdm_mux4_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // SETTLE=1 instance
  logic       rst1_n, start1, cont1, ready1, y1, s0_1, s1_1, fv1, busy1;
  logic [3:0] in1, frame1;
  logic [7:0] cnt1;
  // SETTLE=0 instance
  logic       rst0_n, start0, cont0, ready0, y0, s0_0, s1_0, fv0, busy0;
  logic [3:0] in0, frame0;
  logic [7:0] cnt0;

  // Downstream mux model: {s1,s0}=11 picks i0 ... 00 picks i3.
  assign y1 = in1[2'd3 - {s1_1, s0_1}];
  assign y0 = in0[2'd3 - {s1_0, s0_0}];

  tdm_mux4_scanner #(.SETTLE(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst1_n), .start(start1), .cont(cont1), .y_in(y1),
    .s0(s0_1), .s1(s1_1), .frame(frame1), .frame_valid(fv1),
    .frame_ready(ready1), .busy(busy1), .frame_cnt(cnt1)
  );

  tdm_mux4_scanner #(.SETTLE(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst0_n), .start(start0), .cont(cont0), .y_in(y0),
    .s0(s0_0), .s1(s1_0), .frame(frame0), .frame_valid(fv0),
    .frame_ready(ready0), .busy(busy0), .frame_cnt(cnt0)
  );

  int checks = 0;
  int errors = 0;
  int ec = 0;
  int exp_cnt1 = 0;
  int exp_cnt0 = 0;
  // h*[n] = mux input vector present at rising edge n.
  logic [3:0] h1 [8192];
  logic [3:0] h0 [8192];

  typedef struct {
    logic [3:0] iv;
    logic [3:0] exp_frame;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    h1[(ec + 1) % 8192] = in1;
    h0[(ec + 1) % 8192] = in0;
    @(posedge clk);
    ec++;
    #1;
  endtask

  // Channel k is sampled on edge a + (k+1)*(s+1) after the accept edge a.
  function automatic logic [3:0] model_frame(input int a, input int s, input bit one);
    logic [3:0] f;
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (a + (k + 1) * (s + 1)) % 8192;
      f[k] = one ? h1[idx][k] : h0[idx][k];
    end
    return f;
  endfunction

  // Expected select code e cycles after the accept edge.
  function automatic logic [1:0] exp_sel(input int e, input int s);
    return 2'd3 - 2'(e / (s + 1));
  endfunction

  task automatic run_scan1(input logic [3:0] iv, input bit rnd, input bit noise, input int bp,
                           input string tag, output logic [3:0] got);
    int a;
    logic [3:0] exp;
    logic [1:0] sel_done;
    in1 = iv; start1 = 1'b1;
    step();
    start1 = 1'b0;
    a = ec;
    for (int e = 0; e < 8; e++) begin
      chk($sformatf("%s_sel_e%0d", tag, e), 32'({s1_1, s0_1}), 32'(exp_sel(e, 1)));
      chk($sformatf("%s_valid_early", tag), 32'(fv1), 0);
      chk($sformatf("%s_busy", tag), 32'(busy1), 1);
      if (rnd) in1 = 4'($urandom);
      if (noise) begin
        ready1 = 1'($urandom);
        start1 = 1'($urandom);
      end
      step();
    end
    ready1 = 1'b0; start1 = 1'b0;
    exp = model_frame(a, 1, 1'b1);
    chk($sformatf("%s_valid_edge8", tag), 32'(fv1), 1);
    chk($sformatf("%s_frame", tag), 32'(frame1), 32'(exp));
    chk($sformatf("%s_cnt_pending", tag), 32'(cnt1), 32'(exp_cnt1 % 256));
    got = frame1;
    sel_done = {s1_1, s0_1};
    for (int b = 0; b < bp; b++) begin
      in1 = 4'($urandom);
      step();
      chk($sformatf("%s_bp_valid", tag), 32'(fv1), 1);
      chk($sformatf("%s_bp_frame", tag), 32'(frame1), 32'(exp));
      chk($sformatf("%s_bp_sel", tag), 32'({s1_1, s0_1}), 32'(sel_done));
    end
    ready1 = 1'b1;
    step();
    ready1 = 1'b0;
    exp_cnt1++;
    chk($sformatf("%s_cnt", tag), 32'(cnt1), 32'(exp_cnt1 % 256));
    chk($sformatf("%s_idle", tag), 32'(busy1), 0);
    chk($sformatf("%s_valid_drop", tag), 32'(fv1), 0);
  endtask

  task automatic reset_check1(input string tag);
    #1 rst1_n = 1'b0;
    #1;
    chk($sformatf("%s_busy", tag), 32'(busy1), 0);
    chk($sformatf("%s_sel", tag), 32'({s1_1, s0_1}), 32'h3);
    chk($sformatf("%s_frame", tag), 32'(frame1), 0);
    chk($sformatf("%s_valid", tag), 32'(fv1), 0);
    chk($sformatf("%s_cnt", tag), 32'(cnt1), 0);
    exp_cnt1 = 0;
    @(negedge clk);
    rst1_n = 1'b1;
    step();
    chk($sformatf("%s_stay_idle", tag), 32'(busy1), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] got, iv;
    int a, n;
    logic [1:0] sel_hold;

    tbl[0] = '{iv: 4'b1101, exp_frame: 4'b1101};
    tbl[1] = '{iv: 4'b0000, exp_frame: 4'b0000};
    tbl[2] = '{iv: 4'b1111, exp_frame: 4'b1111};
    tbl[3] = '{iv: 4'b0001, exp_frame: 4'b0001};
    tbl[4] = '{iv: 4'b1000, exp_frame: 4'b1000};
    tbl[5] = '{iv: 4'b0110, exp_frame: 4'b0110};

    rst1_n = 1'b0; start1 = 1'b0; cont1 = 1'b0; ready1 = 1'b0; in1 = 4'd0;
    rst0_n = 1'b0; start0 = 1'b0; cont0 = 1'b0; ready0 = 1'b0; in0 = 4'd0;
    #2;
    chk("rst_sel", 32'({s1_1, s0_1}), 32'h3);
    chk("rst_frame", 32'(frame1), 0);
    chk("rst_valid", 32'(fv1), 0);
    chk("rst_busy", 32'(busy1), 0);
    chk("rst_cnt", 32'(cnt1), 0);
    chk("rst0_busy", 32'(busy0), 0);
    chk("rst0_cnt", 32'(cnt0), 0);
    @(negedge clk);
    rst1_n = 1'b1; rst0_n = 1'b1;
    step();

    // Constant-input single scans from the table.
    for (int i = 0; i < 6; i++) begin
      run_scan1(tbl[i].iv, 1'b0, 1'b0, 0, $sformatf("tbl%0d", i), got);
      chk($sformatf("tbl%0d_vec", i), 32'(got), 32'(tbl[i].exp_frame));
    end

    // Backpressure with toggling inputs.
    run_scan1(4'b1010, 1'b0, 1'b0, 10, "bp", got);

    // Stray start/ready while busy.
    iv = 4'($urandom);
    run_scan1(iv, 1'b0, 1'b1, 0, "ign", got);
    chk("ign_vec", 32'(got), 32'(iv));

    // Random time-varying inputs, noise and backpressure.
    for (int i = 0; i < 15; i++) begin
      run_scan1(4'($urandom), 1'b1, 1'b1, int'($urandom_range(0, 3)), $sformatf("rnd%0d", i), got);
    end

    // Cont dropped mid-scan: frame delivered, then idle with frozen selects.
    cont1 = 1'b1; ready1 = 1'b0; in1 = 4'($urandom);
    step();
    a = ec;
    for (int e = 0; e < 8; e++) begin
      chk($sformatf("cdrop_sel_e%0d", e), 32'({s1_1, s0_1}), 32'(exp_sel(e, 1)));
      if (e == 3) cont1 = 1'b0;
      in1 = 4'($urandom);
      step();
    end
    chk("cdrop_valid", 32'(fv1), 1);
    chk("cdrop_frame", 32'(frame1), 32'(model_frame(a, 1, 1'b1)));
    sel_hold = {s1_1, s0_1};
    ready1 = 1'b1;
    step();
    ready1 = 1'b0;
    exp_cnt1++;
    chk("cdrop_cnt", 32'(cnt1), 32'(exp_cnt1 % 256));
    for (int i = 0; i < 6; i++) begin
      in1 = 4'($urandom);
      step();
      chk("cdrop_idle", 32'(busy1), 0);
      chk("cdrop_sel_hold", 32'({s1_1, s0_1}), 32'(sel_hold));
    end

    // Reset during ch=2 SAMPLE.
    in1 = 4'b1111; start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int e = 0; e < 5; e++) step();
    chk("rmid_sel_pre", 32'({s1_1, s0_1}), 32'h1);
    reset_check1("rmid");

    // Reset while a frame is pending in DONE.
    in1 = 4'b1011; start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int e = 0; e < 8; e++) step();
    chk("rdone_valid_pre", 32'(fv1), 1);
    reset_check1("rdone");
    run_scan1(4'b0101, 1'b0, 1'b0, 0, "post_rst", got);
    chk("post_rst_vec", 32'(got), 32'h5);

    // SETTLE=0: single scans, one select per cycle, valid after 4 edges.
    for (int i = 0; i < 3; i++) begin
      in0 = tbl[i].iv; start0 = 1'b1;
      step();
      start0 = 1'b0;
      a = ec;
      for (int e = 0; e < 4; e++) begin
        chk($sformatf("s0_sel_e%0d", e), 32'({s1_0, s0_0}), 32'(exp_sel(e, 0)));
        chk("s0_valid_early", 32'(fv0), 0);
        step();
      end
      chk("s0_valid_edge4", 32'(fv0), 1);
      chk("s0_frame", 32'(frame0), 32'(tbl[i].exp_frame));
      ready0 = 1'b1;
      step();
      ready0 = 1'b0;
      exp_cnt0++;
      chk("s0_cnt", 32'(cnt0), 32'(exp_cnt0 % 256));
    end

    // Continuous mode: one frame every 5 cycles, counter wraps past 255.
    cont0 = 1'b1; ready0 = 1'b1; in0 = 4'($urandom);
    step();
    a = ec;
    for (int f = 0; f < 260; f++) begin
      n = 0;
      while (!fv0 && n < 12) begin
        in0 = 4'($urandom);
        step();
        n++;
      end
      chk("cont_period", 32'(ec - a), 4);
      chk("cont_frame", 32'(frame0), 32'(model_frame(a, 0, 1'b0)));
      if (!fv0) break;
      if (f == 259) cont0 = 1'b0;
      in0 = 4'($urandom);
      step();
      exp_cnt0++;
      a = ec;
      chk("cont_cnt", 32'(cnt0), 32'(exp_cnt0 % 256));
    end
    ready0 = 1'b0;
    chk("cont_stop_idle", 32'(busy0), 0);
    step();
    chk("cont_stop_idle2", 32'(busy0), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdm_mux4_scanner.md
TDM_MUX4_SCANNER -- requirements
Module: tdm_mux4_scanner

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports clk and rst_n.
REQ-002 The block SHALL have the following parameters.
- SETTLE, default 1: number of cycles (0..15) the selects are held stable before each sample.
- CNT_W, default 8: width of the frame counter.
REQ-003 The block SHALL have the following ports.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-scan request, sampled in IDLE.
- cont  in  1  continuous mode: rescan after every accepted frame.
- y_in  in  1  selected data returned by the downstream 4:1 mux (y3).
- s0  out  1  mux select bit 0.
- s1  out  1  mux select bit 1.
- frame  out  4  assembled word; bit k holds channel ik.
- frame_valid  out  1  frame holds a complete scan.
- frame_ready  in  1  consumer accepts frame.
- busy  out  1  high in any state other than IDLE.
- frame_cnt  out  CNT_W  count of accepted frames.

Function
REQ-004 Channel-to-select encoding SHALL be fixed as {s1,s0}:
- 11 selects i0.
- 10 selects i1.
- 01 selects i2.
- 00 selects i3.
REQ-005 The FSM SHALL have states IDLE, SETTLE, SAMPLE and DONE.
REQ-006 IDLE -> SETTLE SHALL occur when start=1 or cont=1; the channel index is cleared to 0 and frame is cleared to 0.
REQ-007 In SETTLE the selects SHALL show the current channel code; the FSM stays SETTLE cycles, then moves to SAMPLE. If SETTLE=0, SETTLE is skipped and the FSM enters SAMPLE directly.
REQ-008 In SAMPLE, on the clock edge leaving the state, y_in SHALL be written to frame[ch].
- If ch<3: ch increments and the FSM returns to SETTLE.
- If ch=3: the FSM moves to DONE.
REQ-009 Selects SHALL change only on SETTLE/SAMPLE boundaries and never during SETTLE or SAMPLE.
REQ-010 frame_valid SHALL be high only in DONE.
- It rises on the 4*(SETTLE+1)th rising edge after the edge that accepts start.
- This is 8 edges for SETTLE=1 and 4 edges for SETTLE=0.
REQ-011 In DONE, frame SHALL remain stable until frame_valid&&frame_ready. On that edge frame_cnt increments, wrapping modulo 2^CNT_W.
- If cont=1: the FSM goes to SETTLE with ch=0.
- Otherwise: the FSM goes to IDLE.
REQ-012 Handshake and mode rules:
- frame_ready asserted outside DONE SHALL be ignored.
- A start pulse while busy SHALL be ignored, with no queuing.
- Clearing cont mid-scan SHALL complete the current frame, then return to IDLE after acceptance.
REQ-013 A back-to-back continuous scan SHALL begin the cycle after acceptance, with no IDLE bubble.

Reset
REQ-014 While rst_n=0, state SHALL be IDLE immediately, with outputs as follows.
- ch=0.
- {s1,s0}=11.
- frame=0.
- frame_valid=0.
- busy=0.
- frame_cnt=0.
- Settle counter=0.
REQ-015 Reset asserted mid-scan or in DONE SHALL discard the partial or pending frame without incrementing frame_cnt.

Structure
REQ-016 The shared package tdm_pkg SHALL hold the state enum and the 4-entry channel-to-select code constants.
REQ-017 The settle countdown SHALL be a sub-module settle_timer (load, count, done), instantiated once.
REQ-018 The datapath SHALL have no combinational path from y_in to any output.

Verification
REQ-019 Single scan: SETTLE=1, mux inputs i0..i3=1,0,1,1, start pulse -> select sequence 11,10,01,00 with 2 cycles each; frame=4'b1101; frame_valid on edge 8; frame_cnt=1 after ready.
REQ-020 Backpressure: frame_ready=0 for 10 cycles in DONE, inputs toggling -> frame and frame_valid hold; selects unchanged.
REQ-021 Continuous mode: cont=1, ready tied 1, SETTLE=0 -> one frame every 5 cycles; frame_cnt reaches 255 then wraps to 0 (CNT_W=8).
REQ-022 Reset mid-scan: rst_n low during ch=2 SAMPLE -> state IDLE and selects 11 immediately; frame=0; frame_cnt unchanged at 0.
REQ-023 Ignored inputs: start pulsed while busy, and frame_ready pulsed in SETTLE -> no restart, no count change, and frame matches an undisturbed scan.
REQ-024 Cont dropped mid-scan: current frame is delivered, then busy=0 after acceptance, and no further select changes occur.
